// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus between the CPU-side master and the memory/IO responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  modport master (output mem_a, output mem_wr, output mem_dout, input mem_din);
  modport slave  (input mem_a, input mem_wr, input mem_dout, output mem_din);
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: RAM, UART TX/RX FIFOs, halt flag and an
// optional cycle counter at 0x30004..0x30007, enabled by defining CYCLE_COUNTER_EN.
// Read data is registered and appears one cycle after the address.
module mem_io_responder #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  mem_io_responder_if.slave bus,
  output logic              io_buffer_full,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              halt
);

  localparam int unsigned RamDepth = 2 ** ADDR_W;
  localparam int unsigned TxAw     = $clog2(TX_DEPTH);
  localparam int unsigned RxAw     = $clog2(RX_DEPTH);
  localparam logic [TxAw:0] TxFull = (TxAw + 1)'(TX_DEPTH);
  localparam logic [TxAw:0] TxHigh = (TxAw + 1)'(TX_DEPTH - 2);
  localparam logic [RxAw:0] RxFull = (RxAw + 1)'(RX_DEPTH);

  // Bus decode
  logic              io_sel, bus_rd, bus_wr;
  logic [15:0]       io_off;
  logic [ADDR_W-1:0] ram_addr;
  logic              uart_rd, snap_rd, tx_wr, halt_wr, ram_we;
  logic              unused_addr;

  assign io_sel      = (bus.mem_a[17:16] == 2'b11);
  assign io_off      = bus.mem_a[15:0];
  assign ram_addr    = bus.mem_a[ADDR_W-1:0];
  assign bus_rd      = rdy_in & ~bus.mem_wr;
  assign bus_wr      = rdy_in & bus.mem_wr;
  assign uart_rd     = bus_rd & io_sel & (io_off == 16'h0000);
  assign snap_rd     = bus_rd & io_sel & (io_off == 16'h0004);
  assign tx_wr       = bus_wr & io_sel & (io_off == 16'h0000) & (bus.mem_dout != 8'h00);
  assign halt_wr     = bus_wr & io_sel & (io_off == 16'h0004);
  assign ram_we      = bus_wr & ~io_sel;
  assign unused_addr = ^bus.mem_a[31:18];

  // RAM storage; contents deliberately survive reset
  logic [7:0] ram_q [RamDepth];
  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_addr] <= bus.mem_dout;
  end

  // TX FIFO
  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [TxAw-1:0] tx_wptr_q, tx_rptr_q;
  logic [TxAw:0]   tx_cnt_q;
  logic            tx_push, tx_pop, ibf_q;

  assign tx_valid       = (tx_cnt_q != '0);
  assign tx_data        = tx_mem_q[tx_rptr_q];
  assign tx_pop         = tx_valid & tx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign tx_push        = tx_wr & ((tx_cnt_q != TxFull) | tx_pop);
  assign io_buffer_full = ibf_q;

  // TX storage write
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.mem_dout;
  end

  // TX pointers, count and registered high-water flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      ibf_q     <= 1'b0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + {{TxAw{1'b0}}, tx_push} - {{TxAw{1'b0}}, tx_pop};
      ibf_q    <= (tx_cnt_q >= TxHigh);
    end
  end

  // RX FIFO
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [RxAw-1:0] rx_wptr_q, rx_rptr_q;
  logic [RxAw:0]   rx_cnt_q;
  logic            rx_push, rx_pop, rx_empty, rd_run_q;

  assign rx_ready = (rx_cnt_q != RxFull);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = rx_valid & rx_ready;
  // Only the first cycle of a run of 0x30000 reads consumes a byte
  assign rx_pop   = uart_rd & ~rd_run_q & ~rx_empty;

  // RX storage write
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  // RX pointers and count
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + {{RxAw{1'b0}}, rx_push} - {{RxAw{1'b0}}, rx_pop};
    end
  end

  // Cycle counter and snapshot
  logic [7:0] snap_byte;
`ifdef CYCLE_COUNTER_EN
  logic [31:0] cnt_q, snap_q;

  // Counter advances on enabled cycles; snapshot latches on a 0x30004 read
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      if (rdy_in)  cnt_q  <= cnt_q + 32'd1;
      if (snap_rd) snap_q <= cnt_q;
    end
  end

  // Byte 0 comes straight from the counter since the snapshot is being latched this cycle
  always_comb begin
    snap_byte = cnt_q[7:0];
    case (io_off[1:0])
      2'd1:    snap_byte = snap_q[15:8];
      2'd2:    snap_byte = snap_q[23:16];
      2'd3:    snap_byte = snap_q[31:24];
      default: snap_byte = cnt_q[7:0];
    endcase
  end
`else
  logic unused_snap;
  assign unused_snap = snap_rd;
  assign snap_byte   = 8'h00;
`endif

  // Read-data mux; writes and frozen cycles hold the previous value
  logic [7:0] mem_din_d, mem_din_q;
  always_comb begin
    mem_din_d = mem_din_q;
    if (bus_rd) begin
      if (!io_sel) begin
        mem_din_d = ram_q[ram_addr];
      end else if (io_off == 16'h0000) begin
        if (!rd_run_q) mem_din_d = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
      end else if (io_off[15:2] == 14'h0001) begin
        mem_din_d = snap_byte;
      end else begin
        mem_din_d = 8'h00;
      end
    end
  end

  // Read data, read-run edge flag and sticky halt
  logic halt_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= 8'h00;
      rd_run_q  <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      if (rdy_in)  rd_run_q <= uart_rd;
      if (halt_wr) halt_q   <= 1'b1;
    end
  end

  assign bus.mem_din = mem_din_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed, table-driven bench for mem_io_responder (default parameters).
module tb_mem_io_responder;

  logic       clk_in = 1'b0;
  logic       rst_in, rdy_in, tx_ready, rx_valid;
  logic [7:0] rx_data, tx_data;
  logic       io_buffer_full, tx_valid, rx_ready, halt;

  always #5 clk_in = ~clk_in;

  mem_io_responder_if bus_if ();

  mem_io_responder dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .bus           (bus_if),
    .io_buffer_full(io_buffer_full),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .halt          (halt)
  );

  int checks = 0;
  int errors = 0;

  // Reference count of enabled cycles since reset
  logic [31:0] model_cnt;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) model_cnt <= '0;
    else if (rdy_in) model_cnt <= model_cnt + 32'd1;
  end

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_din;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
    rdy_in          = rdy;
    bus_if.mem_wr   = wr;
    bus_if.mem_a    = a;
    bus_if.mem_dout = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 8'h00);
  endtask

  vec_t        vecs [12];
  logic [7:0]  tx_exp [8];
  logic [31:0] exp_snap;

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus_if.mem_a = '0; bus_if.mem_wr = 1'b0; bus_if.mem_dout = '0;

    vecs = '{
      '{1'b1, 32'h0000_0010, 8'hA5, 8'h00},  // write holds reset value
      '{1'b0, 32'h0000_0010, 8'h00, 8'hA5},
      '{1'b1, 32'h0001_FFFF, 8'h3C, 8'hA5},  // top RAM byte
      '{1'b0, 32'h0001_FFFF, 8'h00, 8'h3C},
      '{1'b1, 32'h0000_0000, 8'h77, 8'h3C},
      '{1'b0, 32'h0002_0010, 8'h00, 8'hA5},  // a[17:16]=10 is RAM, aliases 0x10
      '{1'b0, 32'h0000_0000, 8'h00, 8'h77},
      '{1'b0, 32'h0003_0008, 8'h00, 8'h00},  // unmapped IO read
      '{1'b1, 32'h0000_0020, 8'h11, 8'h00},
      '{1'b0, 32'h0000_0020, 8'h00, 8'h11},
      '{1'b1, 32'h0003_0010, 8'h5A, 8'h11},  // ignored IO write
      '{1'b0, 32'h0003_0002, 8'h00, 8'h00}
    };
    tx_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_mem_din", bus_if.mem_din, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_ibf", io_buffer_full, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);
    rst_in = 1'b1;

    // RAM and IO decode table
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].wr, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d_mem_din", i), bus_if.mem_din, vecs[i].exp_din);
    end

    // TX: zero byte is dropped, drain in order
    step(1'b1, 1'b1, 32'h30000, 8'h41);
    step(1'b1, 1'b1, 32'h30000, 8'h00);
    step(1'b1, 1'b1, 32'h30000, 8'h42);
    check("tx_head0", {tx_valid, tx_data}, {1'b1, 8'h41});
    tx_ready = 1'b1;
    idle(1);
    check("tx_head1", {tx_valid, tx_data}, {1'b1, 8'h42});
    idle(1);
    check("tx_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // TX high-water mark, overflow drop, push+pop while full
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 32'h30000, 8'(i));
    check("ibf_at5", io_buffer_full, 1'b0);
    step(1'b1, 1'b1, 32'h30000, 8'h06);
    check("ibf_lag", io_buffer_full, 1'b0);
    step(1'b1, 1'b1, 32'h30000, 8'h07);
    check("ibf_set", io_buffer_full, 1'b1);
    step(1'b1, 1'b1, 32'h30000, 8'h08);
    step(1'b1, 1'b1, 32'h30000, 8'h09);
    tx_ready = 1'b1;
    step(1'b1, 1'b1, 32'h30000, 8'h0A);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("tx_drain%0d", k), {tx_valid, tx_data}, {1'b1, tx_exp[k]});
      idle(1);
    end
    check("tx_drained", tx_valid, 1'b0);
    idle(1);
    check("ibf_clear", io_buffer_full, 1'b0);
    tx_ready = 1'b0;

    // RX: pop only on the first cycle of a read run; pushes ignore rdy_in
    rx_valid = 1'b1; rx_data = 8'h31;
    step(1'b0, 1'b0, 32'h0, 8'h00);
    rx_data = 8'h32;
    step(1'b0, 1'b0, 32'h0, 8'h00);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h30000, 8'h00);
      check($sformatf("rx_run0_%0d", i), bus_if.mem_din, 8'h31);
    end
    idle(1);
    step(1'b1, 1'b0, 32'h30000, 8'h00);
    check("rx_run1", bus_if.mem_din, 8'h32);
    idle(1);
    step(1'b1, 1'b0, 32'h30000, 8'h00);
    check("rx_empty_run", bus_if.mem_din, 8'h00);

    // RX full: rx_ready drops, extra byte refused
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h50 + 8'(i);
      step(1'b0, 1'b0, 32'h0, 8'h00);
    end
    check("rx_full_ready", rx_ready, 1'b0);
    rx_data = 8'hEE;
    step(1'b0, 1'b0, 32'h0, 8'h00);
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      step(1'b1, 1'b0, 32'h30000, 8'h00);
      check($sformatf("rx_full_pop%0d", i), bus_if.mem_din, 8'h50 + 8'(i));
      if (i == 0) check("rx_ready_after_pop", rx_ready, 1'b1);
    end
    idle(1);
    step(1'b1, 1'b0, 32'h30000, 8'h00);
    check("rx_overflow_dropped", bus_if.mem_din, 8'h00);

    // Cycle counter snapshot; rdy_in low cycles do not count
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 32'h0, 8'h00);
    idle(32'h1234);
    exp_snap = model_cnt;
`ifndef CYCLE_COUNTER_EN
    exp_snap = 32'h0;
`endif
    step(1'b1, 1'b0, 32'h30004, 8'h00);
    check("snap_b0", bus_if.mem_din, exp_snap[7:0]);
    idle(300);
    step(1'b1, 1'b0, 32'h30005, 8'h00);
    check("snap_b1", bus_if.mem_din, exp_snap[15:8]);
    step(1'b1, 1'b0, 32'h30006, 8'h00);
    check("snap_b2", bus_if.mem_din, exp_snap[23:16]);
    step(1'b1, 1'b0, 32'h30007, 8'h00);
    check("snap_b3", bus_if.mem_din, exp_snap[31:24]);

    // Halt, freeze and reset
    step(1'b0, 1'b1, 32'h30004, 8'h00);
    check("halt_frozen_write", halt, 1'b0);
    step(1'b1, 1'b1, 32'h30004, 8'h00);
    check("halt_set", halt, 1'b1);
    step(1'b1, 1'b0, 32'h10, 8'h00);
    check("ram_keep", bus_if.mem_din, 8'hA5);
    step(1'b0, 1'b1, 32'h10, 8'h99);
    step(1'b0, 1'b0, 32'h0, 8'h00);
    check("frozen_din", bus_if.mem_din, 8'hA5);
    step(1'b0, 1'b1, 32'h30000, 8'h55);
    check("frozen_tx", tx_valid, 1'b0);
    check("halt_sticky", halt, 1'b1);
    step(1'b1, 1'b0, 32'h10, 8'h00);
    check("frozen_ram_write", bus_if.mem_din, 8'hA5);
    step(1'b1, 1'b1, 32'h30000, 8'h66);
    rx_valid = 1'b1; rx_data = 8'h77;
    step(1'b1, 1'b0, 32'h0, 8'h00);
    rx_valid = 1'b0;
    check("tx_before_rst", tx_valid, 1'b1);
    rst_in = 1'b0;
    #1;
    check("rst2_halt", halt, 1'b0);
    check("rst2_tx_valid", tx_valid, 1'b0);
    check("rst2_mem_din", bus_if.mem_din, 8'h00);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    step(1'b1, 1'b0, 32'h30000, 8'h00);
    check("rst2_rx_empty", bus_if.mem_din, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
